// File: rtl/i2c_wb_seq.sv
// Wishbone sequencer for the I2C master core: programs prescaler/enable after reset, then runs single-byte read/write commands.
// Each core access is request, ack and one idle cycle; commands are accepted only while idle (cmd_ready_o), one at a time.
module i2c_wb_seq #(
    parameter logic [15:0] PRESCALE = 16'd99,
    parameter logic [15:0] POLL_MAX = 16'd4095
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_rw_i,
    input  logic [6:0] cmd_addr_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    output logic [1:0] rsp_status_o,
    output logic [7:0] rsp_data_o,
    output logic [2:0] wb_addr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i
);

    typedef enum logic [3:0] {
        INIT_PL, INIT_PH, INIT_EN, IDLE, ADDR_TX, ADDR_CR, POLL1,
        DATA_TX, DATA_CR, POLL2, RD_RXR, STOP_CR, RESP
    } state_t;

    localparam logic [2:0] REG_PRERLO = 3'd0;
    localparam logic [2:0] REG_PRERHI = 3'd1;
    localparam logic [2:0] REG_CTR    = 3'd2;
    localparam logic [2:0] REG_TXR    = 3'd3;
    localparam logic [2:0] REG_CR     = 3'd4;

    localparam int SR_RXACK = 7;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NACK    = 2'd1;
    localparam logic [1:0] ST_ARB     = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    state_t      state;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic [7:0]  data_q;
    logic [15:0] poll_cnt;

    logic [2:0]  acc_addr;
    logic [7:0]  acc_dat;
    logic        acc_we;

    // Register access each busy state performs; IDLE/RESP never reach the issue path.
    always_comb begin
        acc_addr = REG_CR;
        acc_dat  = 8'h00;
        acc_we   = 1'b1;
        case (state)
            INIT_PL: begin acc_addr = REG_PRERLO; acc_dat = PRESCALE[7:0];  end
            INIT_PH: begin acc_addr = REG_PRERHI; acc_dat = PRESCALE[15:8]; end
            INIT_EN: begin acc_addr = REG_CTR;    acc_dat = 8'h80;          end
            ADDR_TX: begin acc_addr = REG_TXR;    acc_dat = {addr_q, rw_q}; end
            ADDR_CR: acc_dat = 8'h90;
            DATA_TX: begin acc_addr = REG_TXR;    acc_dat = data_q;         end
            DATA_CR: acc_dat = rw_q ? 8'h68 : 8'h50;
            POLL1, POLL2: acc_we = 1'b0;
            RD_RXR:  begin acc_addr = REG_TXR;    acc_we = 1'b0;            end
            STOP_CR: acc_dat = 8'h40;
            default: acc_we = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= INIT_PL;
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_status_o <= ST_OK;
            rsp_data_o   <= 8'h00;
            wb_addr_o    <= 3'd0;
            wb_dat_o     <= 8'h00;
            wb_we_o      <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_cyc_o     <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= 7'd0;
            data_q       <= 8'h00;
            poll_cnt     <= 16'd0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        rw_q         <= cmd_rw_i;
                        addr_q       <= cmd_addr_i;
                        data_q       <= cmd_data_i;
                        cmd_ready_o  <= 1'b0;
                        rsp_status_o <= ST_OK;
                        rsp_data_o   <= 8'h00;
                        state        <= ADDR_TX;
                    end
                end
                RESP: begin
                    cmd_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    if (!wb_stb_o) begin
                        wb_stb_o  <= 1'b1;
                        wb_cyc_o  <= 1'b1;
                        wb_we_o   <= acc_we;
                        wb_addr_o <= acc_addr;
                        wb_dat_o  <= acc_dat;
                    end else if (wb_ack_i) begin
                        // Dropping stb here and issuing from the next state gives the mandatory idle cycle.
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        case (state)
                            INIT_PL: state <= INIT_PH;
                            INIT_PH: state <= INIT_EN;
                            INIT_EN: begin
                                state       <= IDLE;
                                cmd_ready_o <= 1'b1;
                            end
                            ADDR_TX: state <= ADDR_CR;
                            ADDR_CR: begin
                                state    <= POLL1;
                                poll_cnt <= 16'd0;
                            end
                            DATA_TX: state <= DATA_CR;
                            DATA_CR: begin
                                state    <= POLL2;
                                poll_cnt <= 16'd0;
                            end
                            POLL1, POLL2: begin
                                if (poll_cnt != POLL_MAX)
                                    poll_cnt <= poll_cnt + 16'd1;
                                if (wb_dat_i[SR_TIP]) begin
                                    if (poll_cnt >= POLL_MAX - 16'd1) begin
                                        rsp_status_o <= ST_TIMEOUT;
                                        state        <= STOP_CR;
                                    end
                                end else if (wb_dat_i[SR_AL]) begin
                                    // Bus is no longer ours, so no STOP is attempted.
                                    rsp_status_o <= ST_ARB;
                                    rsp_valid_o  <= 1'b1;
                                    state        <= RESP;
                                end else if (state == POLL1) begin
                                    if (wb_dat_i[SR_RXACK]) begin
                                        rsp_status_o <= ST_NACK;
                                        state        <= STOP_CR;
                                    end else begin
                                        state <= rw_q ? DATA_CR : DATA_TX;
                                    end
                                end else if (rw_q) begin
                                    state <= RD_RXR;
                                end else begin
                                    if (wb_dat_i[SR_RXACK])
                                        rsp_status_o <= ST_NACK;
                                    rsp_valid_o <= 1'b1;
                                    state       <= RESP;
                                end
                            end
                            RD_RXR: begin
                                rsp_data_o  <= wb_dat_i;
                                rsp_valid_o <= 1'b1;
                                state       <= RESP;
                            end
                            STOP_CR: begin
                                rsp_valid_o <= 1'b1;
                                state       <= RESP;
                            end
                            default: state <= INIT_PL;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_wb_seq.md
# i2c_wb_seq

Wishbone master sequencer that drives the I2C master core's register file on behalf of a simple command port. After reset it programs the prescaler and enables the core. It then executes single-byte I2C write or read transactions: address phase, data phase, STOP, TIP polling, ACK/arbitration checks. The block sits between system logic and the I2C core's Wishbone slave port, sharing its clock and reset, and owns that port exclusively.

## Interface
- PRESCALE, 16'd99, value written to PRERlo/PRERhi during init
- POLL_MAX, 16'd4095, maximum SR reads per TIP poll before timeout

- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  block idle and initialised; command accepted when valid && ready
- cmd_rw_i  in  1  0 = write byte, 1 = read byte
- cmd_addr_i  in  7  I2C slave address
- cmd_data_i  in  8  write data (ignored for reads)
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_status_o  out  2  0 OK, 1 NACK, 2 ARB_LOST, 3 TIMEOUT
- rsp_data_o  out  8  read data (0 for writes or on error)
- wb_addr_o  out  3  register address to core
- wb_dat_o  out  8  write data to core
- wb_dat_i  in  8  read data from core
- wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  Wishbone master controls
- wb_ack_i  in  1  core acknowledge

## Operation
- Core register map:
  - 0 PRERlo
  - 1 PRERhi
  - 2 CTR (bit7 EN)
  - 3 TXR (write) / RXR (read)
  - 4 CR (write) / SR (read)
- CR bits: STA7, STO6, RD5, WR4, ACK3, IACK0.
- SR bits: RxACK7, BUSY6, AL5, TIP1, IF0.
- States: INIT_PL, INIT_PH, INIT_EN, IDLE, ADDR_TX, ADDR_CR, POLL1, DATA_TX, DATA_CR, POLL2, RD_RXR, STOP_CR, RESP.
- Init sequence: write PRERlo=PRESCALE[7:0], PRERhi=PRESCALE[15:8], CTR=0x80, then enter IDLE.
- Write command:
  - TXR={addr,0}, CR=0x90, POLL1.
  - TXR=data, CR=0x50, POLL2, RESP.
- Read command:
  - TXR={addr,1}, CR=0x90, POLL1.
  - CR=0x68 (STO|RD|NACK), POLL2, read RXR into rsp_data_o, RESP.
- Poll: read SR repeatedly until TIP=0, then evaluate the final SR.
  - AL=1: status ARB_LOST, go to RESP. No STOP is issued.
  - Else RxACK=1 in POLL1: status NACK, go to STOP_CR.
  - Else RxACK=1 in POLL2 of a write: status NACK, go to RESP (STOP already issued).
  - RxACK is ignored in POLL2 of a read, because the master NACKs.
  - POLL_MAX reads with TIP still 1: status TIMEOUT, go to STOP_CR.
- STOP_CR writes CR=0x40, then goes to RESP.
- Command fields are latched on acceptance. Input changes afterwards have no effect.

## Timing
- Wishbone access:
  - Cycle 0: cyc/stb/addr/we/dat asserted.
  - Signals held until the cycle wb_ack_i=1 is sampled; wb_dat_i is captured in that cycle.
  - cyc/stb deassert next cycle; at least one idle cycle before the next access.
  - No ack timeout.
- With single-cycle registered ack, each access takes 3 cycles. Init completes and cmd_ready_o rises 9 cycles after reset deassertion.
- cmd_ready_o is 1 only in IDLE and drops the cycle after acceptance.
- rsp_valid_o pulses exactly one cycle in RESP. cmd_ready_o rises the following cycle.
- cmd_valid_i is ignored while not ready, including during init.
- Reset values: all outputs 0, state INIT_PL, status 0, poll counter 0.
- Reset mid-access: stb/cyc are 0 on the first cycle after reset is sampled. No rsp_valid_o is generated. Init restarts; the core shares wb_rst_i.
- Poll counter is 16 bits. It clears on entry to each POLL state and saturates at POLL_MAX; it never wraps.

## Test plan
- Reset release -> exactly three WB writes (0:0x63, 1:0x00, 2:0x80) with PRESCALE=99. cmd_ready_o=1 at cycle 9.
- Write addr=0x50 data=0xA5, slave ACKs -> WB writes 3:0xA0, 4:0x90, SR polls, 3:0xA5, 4:0x50. rsp_status=0, rsp_data=0.
- Read addr=0x50, slave returns 0x3C -> writes 3:0xA1, 4:0x90, later 4:0x68, then RXR read. rsp_status=0, rsp_data=0x3C.
- Address NACK (SR=0x80 after TIP clears) -> CR=0x40 written, rsp_status=1, no data phase.
- SR with AL=1 -> rsp_status=2, no STOP write. TIP stuck with POLL_MAX=8 -> 8 SR reads, CR=0x40, rsp_status=3.
- Reset asserted mid POLL2 -> stb/cyc low next cycle, no rsp pulse, init sequence replays. cmd_valid_i held high during busy -> only one command accepted.
